// File: rtl/fetch_if.sv
// fetch_if: instruction-memory handshake, redirect input and IF->ID outputs of the fetch stage
interface fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_stall;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic        misalign;
    modport master (
        output imem_req, imem_addr, if_valid, if_inst, if_pc, if_pc_plus4, misalign,
        input  imem_ack, imem_rdata, redirect_valid, redirect_pc, id_stall
    );
    modport slave (
        input  imem_req, imem_addr, if_valid, if_inst, if_pc, if_pc_plus4, misalign,
        output imem_ack, imem_rdata, redirect_valid, redirect_pc, id_stall
    );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: MIPS IF stage; owns the PC, keeps one imem request in flight and
// buffers returned words in a 2-entry queue ahead of the ID stage.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    en,
    fetch_if.master bus
);
    typedef enum logic [1:0] {RUN, WAIT, DROP} state_t;
    state_t      state, state_nx;
    logic [31:0] fetch_pc, req_pc;
    logic [31:0] q_inst [2];
    logic [31:0] q_pc [2];
    logic [1:0]  cnt, cnt_nx;
    logic        redir, push, pop, issue, wr_idx, misalign_q;
    assign redir  = bus.redirect_valid;
    assign pop    = cnt != 2'd0 && !bus.id_stall && en && !redir;
    assign push   = state == WAIT && bus.imem_ack && !redir;
    assign cnt_nx = redir ? 2'd0 : cnt + {1'b0, push} - {1'b0, pop};
    // slot for an incoming word is counted after this cycle's pop
    assign wr_idx = cnt[0] ^ pop;
    always_comb begin
        issue    = !rst && en && !redir && cnt_nx < 2'(QDEPTH) && (state == RUN || push);
        state_nx = issue                                ? WAIT :
                   (bus.imem_ack && state != RUN)       ? RUN  :
                   (redir && state == WAIT)             ? DROP : state;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RUN;
            fetch_pc   <= RESET_PC;
            req_pc     <= RESET_PC;
            cnt        <= 2'd0;
            misalign_q <= 1'b0;
            q_inst[0]  <= '0;
            q_inst[1]  <= '0;
            q_pc[0]    <= '0;
            q_pc[1]    <= '0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            misalign_q <= redir && bus.redirect_pc[1:0] != 2'b00;
            fetch_pc   <= redir ? {bus.redirect_pc[31:2], 2'b00} : issue ? fetch_pc + 32'd4 : fetch_pc;
            if (issue)
                req_pc <= fetch_pc;
            if (pop) begin
                q_inst[0] <= q_inst[1];
                q_pc[0]   <= q_pc[1];
            end
            if (push) begin
                q_inst[wr_idx] <= bus.imem_rdata;
                q_pc[wr_idx]   <= req_pc;
            end
        end
    end
    assign bus.imem_req    = issue;
    assign bus.imem_addr   = fetch_pc;
    assign bus.if_valid    = cnt != 2'd0;
    assign bus.if_inst     = q_inst[0];
    assign bus.if_pc       = q_pc[0];
    assign bus.if_pc_plus4 = q_pc[0] + 32'd4;
    assign bus.misalign    = misalign_q;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: randomized and directed checks of fetch_stage against a program-order
// reference model; expected instruction stream is queued by the stimulus side.
module tb_fetch_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b1;
    fetch_if bus ();
    fetch_stage #(.RESET_PC(32'h0000_0000), .QDEPTH(2)) dut (.clk(clk), .rst(rst), .en(en), .bus(bus));
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;
    exp_t        exp_q[$];
    logic [31:0] next_pc, exp_addr;
    int          vectors = 0, miscompares = 0;
    int          lat = 1;
    bit          rand_lat = 1'b0;
    bit          pend = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // the program is fetched in order from the last restart point
    task automatic refill();
        while (exp_q.size() < 4) begin
            exp_q.push_back('{pc: next_pc, inst: mem_word(next_pc)});
            next_pc += 32'd4;
        end
    endtask

    task automatic model_restart(input logic [31:0] pc);
        exp_q.delete();
        next_pc  = {pc[31:2], 2'b00};
        exp_addr = {pc[31:2], 2'b00};
        refill();
    endtask

    // instruction memory: one response per request, lat cycles later
    initial begin
        logic        req_s;
        logic [31:0] addr_s, paddr;
        int          mcnt;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = '0;
        paddr = '0;
        mcnt  = 0;
        forever begin
            @(negedge clk);
            req_s  = bus.imem_req && !rst;
            addr_s = bus.imem_addr;
            @(posedge clk);
            #1;
            bus.imem_ack   = 1'b0;
            bus.imem_rdata = $urandom;
            if (rst) pend = 1'b0;
            else begin
                if (req_s) begin
                    pend  = 1'b1;
                    paddr = addr_s;
                    mcnt  = rand_lat ? int'($urandom_range(4, 1)) : lat;
                end
                if (pend) begin
                    if (mcnt == 1) begin
                        bus.imem_ack   = 1'b1;
                        bus.imem_rdata = mem_word(paddr);
                        pend = 1'b0;
                    end else mcnt--;
                end
            end
        end
    end

    // monitor / scoreboard
    logic prev_rv = 1'b0, prev_mis = 1'b0;
    int   idle = 0;
    always @(negedge clk) begin
        exp_t e;
        bit   acc;
        if (rst) begin
            prev_rv  = 1'b0;
            prev_mis = 1'b0;
            idle     = 0;
        end else begin
            chk("misalign", bus.misalign, prev_mis);
            if (prev_rv) chk("valid_after_redirect", bus.if_valid, 0);
            if (bus.imem_req) begin
                chk("req_addr", bus.imem_addr, exp_addr);
                chk("req_outstanding", pend, 0);
                chk("req_while_blocked", !en || bus.redirect_valid, 0);
                exp_addr += 32'd4;
            end
            if (bus.if_valid) chk("pc_plus4", bus.if_pc_plus4, bus.if_pc + 32'd4);
            acc = bus.if_valid && !bus.id_stall && en && !bus.redirect_valid;
            if (acc) begin
                idle = 0;
                if (exp_q.size() == 0) chk("scoreboard_empty", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("if_pc", bus.if_pc, e.pc);
                    chk("if_inst", bus.if_inst, e.inst);
                    refill();
                end
            end else if (en && !bus.id_stall && !bus.redirect_valid) idle++;
            if (bus.redirect_valid) idle = 0;
            if (idle > 30) begin
                chk("progress_idle_cycles", idle, 30);
                idle = 0;
            end
            prev_rv  = bus.redirect_valid;
            prev_mis = bus.redirect_valid && bus.redirect_pc[1:0] != 2'b00;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic next_req(output int gap);
        bit hit;
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
            hit = bus.imem_req;
            cyc();
        end while (!hit && gap < 20);
        if (!hit) chk("req_timeout", 0, 1);
    endtask

    task automatic check_reset_values();
        chk("rst_imem_req", bus.imem_req, 0);
        chk("rst_imem_addr", bus.imem_addr, 32'h0);
        chk("rst_if_valid", bus.if_valid, 0);
        chk("rst_if_inst", bus.if_inst, 32'h0);
        chk("rst_if_pc", bus.if_pc, 32'h0);
        chk("rst_if_pc_plus4", bus.if_pc_plus4, 32'h4);
        chk("rst_misalign", bus.misalign, 0);
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = pc;
        model_restart(pc);
    endtask

    initial begin
        int g;
        bit found;
        logic [31:0] r;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.id_stall       = 1'b0;
        model_restart(32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_values();
        cyc();
        rst = 1'b0;
        // streaming from reset with 1-cycle memory
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("stream_req", bus.imem_req, 1);
            chk("stream_addr", bus.imem_addr, 32'(4 * i));
            chk("stream_valid", bus.if_valid, 32'(i >= 2));
            if (i >= 2) chk("stream_if_pc", bus.if_pc, 32'(4 * (i - 2)));
            cyc();
        end
        // ID stall fills the queue and blocks further requests
        bus.id_stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i >= 2) chk("stall_no_req", bus.imem_req, 0);
            chk("stall_valid", bus.if_valid, 1);
            chk("stall_head", bus.if_pc, exp_q[0].pc);
            cyc();
        end
        bus.id_stall = 1'b0;
        repeat (8) cyc();
        // slow memory: one request per lat cycles
        lat = 4;
        next_req(g);
        for (int i = 0; i < 3; i++) begin
            next_req(g);
            chk("req_gap", g, 4);
        end
        // redirect while a request is outstanding
        lat = 3;
        next_req(g);
        next_req(g);
        redirect_to(32'h0000_0100);
        @(negedge clk);
        chk("redir_no_req", bus.imem_req, 0);
        cyc();
        bus.redirect_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("drop_valid", bus.if_valid, 0);
            chk("drop_no_req", bus.imem_req, 0);
            cyc();
        end
        @(negedge clk);
        chk("after_drop_req", bus.imem_req, 1);
        chk("after_drop_addr", bus.imem_addr, 32'h100);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cyc();
            @(negedge clk);
            if (bus.if_valid) begin
                found = 1'b1;
                chk("redir_first_pc", bus.if_pc, 32'h100);
            end
        end
        if (!found) chk("redir_valid_timeout", 0, 1);
        cyc();
        // redirect coincident with ack and pop
        lat = 1;
        repeat (8) cyc();
        redirect_to(32'h0000_0200);
        @(negedge clk);
        chk("coinc_valid_before", bus.if_valid, 1);
        cyc();
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        chk("coinc_valid_after", bus.if_valid, 0);
        chk("coinc_req", bus.imem_req, 1);
        chk("coinc_addr", bus.imem_addr, 32'h200);
        cyc();
        // misaligned redirect target
        repeat (4) cyc();
        redirect_to(32'h0000_0102);
        @(negedge clk);
        chk("mis_before", bus.misalign, 0);
        cyc();
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        chk("mis_pulse", bus.misalign, 1);
        chk("mis_addr", bus.imem_addr, 32'h100);
        cyc();
        @(negedge clk);
        chk("mis_clear", bus.misalign, 0);
        cyc();
        // en=0 with a request outstanding
        lat = 3;
        repeat (3) next_req(g);
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("en0_no_req", bus.imem_req, 0);
            chk("en0_valid", bus.if_valid, 1);
            chk("en0_head", bus.if_pc, exp_q[0].pc);
            cyc();
        end
        en = 1'b1;
        @(negedge clk);
        chk("en1_req", bus.imem_req, 1);
        cyc();
        // PC wrap
        lat = 1;
        repeat (8) cyc();
        redirect_to(32'hFFFF_FFFC);
        cyc();
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        chk("wrap_addr0", bus.imem_addr, 32'hFFFF_FFFC);
        cyc();
        @(negedge clk);
        chk("wrap_addr1", bus.imem_addr, 32'h0);
        cyc();
        @(negedge clk);
        chk("wrap_if_pc", bus.if_pc, 32'hFFFF_FFFC);
        chk("wrap_plus4", bus.if_pc_plus4, 32'h0);
        cyc();
        // randomized traffic
        rand_lat = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            bus.id_stall = $urandom_range(99, 0) < 30;
            en = $urandom_range(99, 0) >= 8;
            if ($urandom_range(99, 0) < 4) begin
                r = $urandom;
                redirect_to($urandom_range(3, 0) == 0 ? {28'hFFF_FFFF, r[3:0]} : r);
            end else bus.redirect_valid = 1'b0;
            if (c == 2000) begin
                bus.redirect_valid = 1'b0;
                rst = 1'b1;
                model_restart(32'h0);
                @(negedge clk);
                check_reset_values();
                cyc();
                cyc();
                rst = 1'b0;
            end
            cyc();
        end
        bus.redirect_valid = 1'b0;
        repeat (4) cyc();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
